servant_acc_seq: RTL and testbench

//  Command sequencer between the servant_mux accelerator port and Matrix_TOP. CPU pushes

---
 rtl/servant_acc_seq_pkg.sv | 24 ++
 rtl/servant_acc_seq_fifo.sv | 39 +++
 rtl/servant_acc_seq.sv | 112 +++++++++++
 tb/tb_servant_acc_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/servant_acc_seq_pkg.sv
// servant_acc_seq_pkg: register map, status bits, opcodes, FSM states and FIFO entry layout
package servant_acc_seq_pkg;
  localparam logic [2:0] REG_ADR = 3'd0;
  localparam logic [2:0] REG_WDAT = 3'd1;
  localparam logic [2:0] REG_RDREQ = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_RDATA = 3'd4;
  localparam logic [2:0] REG_POLL = 3'd5;
  localparam int ST_BUSY = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL = 2;
  localparam int ST_RVALID = 3;
  localparam int ST_DONE = 4;
  localparam int ST_TIMEOUT = 5;
  localparam int ST_OVF = 6;
  typedef enum logic [1:0] {OP_WR = 2'd0, OP_RD = 2'd1, OP_POLL = 2'd2} op_e;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_POLL_WAIT, S_POLL_CHK} state_e;
  typedef struct packed {
    op_e op;
    logic [12:0] adr;
    logic [31:0] dat;
  } cmd_t;
  localparam int ENTRY_W = $bits(cmd_t);
endpackage

// File: rtl/servant_acc_seq_fifo.sv
// servant_acc_seq_fifo: first-word-fall-through sync FIFO with flush; full/empty from pointer MSBs
module servant_acc_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 47
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // a push into a full FIFO is still taken when the head leaves in the same cycle
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop = pop && !empty && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/servant_acc_seq.sv
// servant_acc_seq: Wishbone-fed command FIFO replayed as write/read/poll on the accelerator bus
module servant_acc_seq
  import servant_acc_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [12:0] o_acc_adr,
  output logic [31:0] o_acc_dat,
  output logic        o_acc_we,
  input  logic [31:0] i_acc_rdt,
  output logic        o_irq
);
  localparam int CW = $clog2(RD_LAT + 1);
  state_e state, next;
  cmd_t push_cmd, head;
  logic stb, wr, rd, push, pop, full, empty, w1c, ovf_set;
  logic poll_st, lat_done, capture, done_set, tmo_set, hit;
  logic ovf, tmo, done, rvalid;
  logic [CW-1:0] cnt;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [4:0] bit_q;
  logic [12:0] adr_q;
  logic [31:0] rdata, status;
  assign stb = i_wb_cyc && !o_wb_ack;
  assign wr = stb && i_wb_we;
  assign rd = stb && !i_wb_we;
  assign push = wr && (i_wb_adr == REG_WDAT || i_wb_adr == REG_RDREQ || i_wb_adr == REG_POLL);
  assign w1c = wr && i_wb_adr == REG_STATUS;
  assign pop = state == S_IDLE && !empty;
  assign ovf_set = push && full && !pop;
  assign poll_st = state == S_POLL_WAIT || state == S_POLL_CHK;
  assign lat_done = cnt == CW'(RD_LAT);
  assign capture = state == S_RD_WAIT && lat_done;
  assign done_set = state == S_POLL_CHK && hit;
  assign tmo_set = poll_st && &tcnt && !done_set;
  assign status = {25'b0, ovf, tmo, done, rvalid, full, empty, state != S_IDLE || !empty};
  assign o_irq = done || tmo;
  assign push_cmd = '{
    op:  i_wb_adr == REG_WDAT ? OP_WR : i_wb_adr == REG_RDREQ ? OP_RD : OP_POLL,
    adr: i_wb_adr == REG_WDAT ? adr_q : i_wb_dat[12:0],
    dat: i_wb_adr == REG_WDAT ? i_wb_dat : i_wb_adr == REG_POLL ? {27'b0, i_wb_dat[20:16]} : 32'b0
  };
  servant_acc_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .flush(tmo_set),
    .push(push),
    .pop(pop),
    .din(push_cmd),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    next = state;
    case (state)
      S_IDLE:      next = empty ? S_IDLE : head.op == OP_WR ? S_WR : head.op == OP_RD ? S_RD_WAIT : S_POLL_WAIT;
      S_WR:        next = S_IDLE;
      S_RD_WAIT:   next = lat_done ? S_IDLE : S_RD_WAIT;
      S_POLL_WAIT: next = tmo_set ? S_IDLE : lat_done ? S_POLL_CHK : S_POLL_WAIT;
      S_POLL_CHK:  next = (done_set || tmo_set) ? S_IDLE : S_POLL_WAIT;
      default:     next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      tcnt <= '0;
      hit <= 1'b0;
      bit_q <= '0;
      adr_q <= '0;
      rdata <= '0;
      ovf <= 1'b0;
      tmo <= 1'b0;
      done <= 1'b0;
      rvalid <= 1'b0;
      o_acc_adr <= '0;
      o_acc_dat <= '0;
      o_acc_we <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      state <= next;
      cnt <= ((state == S_RD_WAIT || state == S_POLL_WAIT) && !lat_done) ? cnt + CW'(1) : '0;
      tcnt <= pop ? '0 : poll_st ? tcnt + 1'b1 : tcnt;
      hit <= (state == S_POLL_WAIT && lat_done) ? i_acc_rdt[bit_q] : hit;
      bit_q <= pop ? head.dat[4:0] : bit_q;
      adr_q <= (wr && i_wb_adr == REG_ADR) ? i_wb_dat[12:0] : adr_q;
      rdata <= capture ? i_acc_rdt : rdata;
      // setting a flag outranks a same-cycle clear from the CPU
      ovf <= ovf_set || (ovf && !(w1c && i_wb_dat[ST_OVF]));
      tmo <= tmo_set || (tmo && !(w1c && i_wb_dat[ST_TIMEOUT]));
      done <= done_set || (done && !(w1c && i_wb_dat[ST_DONE]));
      rvalid <= capture || (rvalid && !(rd && i_wb_adr == REG_RDATA));
      o_acc_adr <= pop ? head.adr : o_acc_adr;
      o_acc_dat <= (pop && head.op == OP_WR) ? head.dat : o_acc_dat;
      o_acc_we <= pop && head.op == OP_WR;
      o_wb_ack <= stb;
      o_wb_rdt <= !rd ? '0 : i_wb_adr == REG_STATUS ? status : i_wb_adr == REG_RDATA ? rdata : '0;
    end
endmodule

// File: tb/tb_servant_acc_seq.sv
// tb_servant_acc_seq: vector table, directed corner sequences and random traffic vs a memory reference
module tb_servant_acc_seq;
  import servant_acc_seq_pkg::*;
  localparam int RD_LAT = 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [2:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic wb_we = 0, wb_cyc = 0;
  logic [31:0] rdt1, rdt2, adat1, adat2, ardt1;
  logic [12:0] aadr1, aadr2;
  logic ack1, ack2, awe1, awe2, irq1, irq2;
  servant_acc_seq #(.RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_acc_adr(aadr1),
    .o_acc_dat(adat1), .o_acc_we(awe1), .i_acc_rdt(ardt1), .o_irq(irq1)
  );
  servant_acc_seq #(.RD_LAT(RD_LAT), .TIMEOUT_W(4)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .o_wb_rdt(rdt2), .o_wb_ack(ack2), .o_acc_adr(aadr2),
    .o_acc_dat(adat2), .o_acc_we(awe2), .i_acc_rdt(32'h0), .o_irq(irq2)
  );

  bit [31:0] mem [8192];
  logic [31:0] pipe [RD_LAT];
  bit poll_set = 0;
  logic [44:0] wlog [$];
  int we2_cnt = 0, cyc_n = 0, last_lo = 0;
  // accelerator model: memory written by WR strobes, read data delayed RD_LAT cycles
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!irq2) last_lo <= cyc_n;
    if (awe2) we2_cnt <= we2_cnt + 1;
    if (awe1) begin
      mem[aadr1] <= adat1;
      wlog.push_back({aadr1, adat1});
    end
    pipe[0] <= mem[aadr1] | ((aadr1 == 13'h1FFF && poll_set) ? 32'h8 : 32'h0);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ardt1 = pipe[RD_LAT-1];

  int n_cmp = 0, n_err = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [2:0] a, input logic [31:0] d,
                    output logic [31:0] r1, output logic [31:0] r2);
    @(negedge clk);
    wb_cyc = 1; wb_we = we; wb_adr = a; wb_dat = d;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack1) break;
    end
    if (!ack1) check("wb_ack", ack1, 1);
    r1 = rdt1; r2 = rdt2;
    wb_cyc = 0; wb_we = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] x, y;
    wb(1, a, d, x, y);
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] r1, output logic [31:0] r2);
    wb(0, a, 32'h0, r1, r2);
  endtask
  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r1, r2;
    rd(a, r1, r2);
    check(nm, r1, exp);
  endtask
  task automatic wait_idle();
    logic [31:0] s, s2;
    for (int k = 0; k < 60; k++) begin
      rd(REG_STATUS, s, s2);
      if (!s[ST_BUSY]) break;
    end
    check("wait_idle", s[ST_BUSY], 0);
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  typedef struct {logic we; logic [2:0] adr; logic [31:0] dat; logic chk; logic [31:0] exp;} vec_t;
  vec_t tbl [8];

  initial begin
    logic [31:0] r1, r2;
    int base, t0, b2, d;
    bit [31:0] ref_mem [int];
    logic [44:0] exp_log [$];
    tbl[0] = '{1, 3'd7, 32'hFFFF_FFFF, 0, 0};
    tbl[1] = '{0, 3'd7, 0, 1, 32'h0};
    tbl[2] = '{0, 3'd6, 0, 1, 32'h0};
    tbl[3] = '{0, REG_ADR, 0, 1, 32'h0};
    tbl[4] = '{0, REG_STATUS, 0, 1, 32'h2};
    tbl[5] = '{1, REG_STATUS, 32'hFFFF_FFFF, 0, 0};
    tbl[6] = '{0, REG_RDATA, 0, 1, 32'h0};
    tbl[7] = '{0, REG_STATUS, 0, 1, 32'h2};
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("reset_outputs", {aadr1, adat1, awe1, ack1, rdt1, irq1}, 0);
    rd(REG_STATUS, r1, r2);
    check("reset_status", r1, 32'h2);
    check("reset_status_t", r2, 32'h2);
    foreach (tbl[i]) begin
      wb(tbl[i].we, tbl[i].adr, tbl[i].dat, r1, r2);
      if (tbl[i].chk) check($sformatf("tbl%0d", i), r1, tbl[i].exp);
    end

    base = wlog.size();
    wr(REG_ADR, 32'h10);
    wr(REG_WDAT, 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    check("wr_count", wlog.size() - base, 1);
    check("wr_entry", wlog[base], {13'h010, 32'hDEADBEEF});
    rd_chk("wr_status", REG_STATUS, 32'h2);

    wr(REG_ADR, 32'h20);
    wr(REG_WDAT, 32'h1234);
    wr(REG_RDREQ, 32'h20);
    repeat (6) @(posedge clk);
    rd_chk("rd_status_valid", REG_STATUS, 32'hA);
    rd_chk("rd_rdata", REG_RDATA, 32'h1234);
    rd_chk("rd_status_clear", REG_STATUS, 32'h2);

    poll_set = 0;
    wr(REG_POLL, (32'd3 << 16) | 32'h1FFF);
    repeat (20) @(posedge clk);
    #1;
    check("poll_irq_early", irq1, 0);
    rd_chk("poll_status_busy", REG_STATUS, 32'h3);
    poll_set = 1;
    for (int k = 0; k < 20 && !irq1; k++) begin @(posedge clk); #1; end
    check("poll_irq", irq1, 1);
    rd_chk("poll_status_done", REG_STATUS, 32'h12);
    wr(REG_STATUS, 32'h10);
    check("poll_irq_cleared", irq1, 0);
    rd_chk("poll_status_after_w1c", REG_STATUS, 32'h2);

    poll_set = 0;
    wr(REG_ADR, 32'h100);
    wr(REG_POLL, (32'd3 << 16) | 32'h1FFF);
    base = wlog.size();
    for (int i = 0; i < 9; i++) wr(REG_WDAT, 32'hA0 + i);
    rd_chk("ovf_status", REG_STATUS, 32'h45);
    poll_set = 1;
    repeat (30) @(posedge clk);
    check("ovf_wr_count", wlog.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("ovf_wr%0d", i), wlog[base+i], {13'h100, 32'hA0 + i});
    rd_chk("ovf_status_drained", REG_STATUS, 32'h52);
    wr(REG_STATUS, 32'h70);
    rd_chk("ovf_status_cleared", REG_STATUS, 32'h2);

    do_reset();
    poll_set = 0;
    wr(REG_POLL, (32'd3 << 16) | 32'h1FFF);
    t0 = cyc_n;
    b2 = we2_cnt;
    wr(REG_WDAT, 32'h1);
    wr(REG_WDAT, 32'h2);
    wr(REG_WDAT, 32'h3);
    repeat (30) @(posedge clk);
    #1;
    check("tmo_irq", irq2, 1);
    d = last_lo - t0;
    check("tmo_cycles_in_window", (d >= 14 && d <= 18), 1);
    rd(REG_STATUS, r1, r2);
    check("tmo_status", r2, 32'h22);
    check("tmo_no_writes", we2_cnt - b2, 0);

    do_reset();
    wr(REG_ADR, 32'h1AB);
    wr(REG_WDAT, 32'h55AA55AA);
    repeat (3) @(posedge clk);
    wr(REG_RDREQ, 32'h1AB);
    @(posedge clk); #1;
    check("midrd_adr", aadr1, 13'h1AB);
    rst = 1;
    #1;
    check("midrd_reset_outputs", {aadr1, adat1, awe1, ack1, rdt1, irq1}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(posedge clk);
    rd_chk("midrd_status", REG_STATUS, 32'h2);

    do_reset();
    base = wlog.size();
    for (int n = 0; n < 40; n++) begin
      logic [12:0] a;
      logic [31:0] v;
      a = 13'($urandom_range(32'h200, 32'h2FF));
      if ($urandom_range(0, 2) != 0) begin
        v = $urandom;
        wr(REG_ADR, {19'b0, a});
        wr(REG_WDAT, v);
        ref_mem[int'(a)] = v;
        exp_log.push_back({a, v});
      end else begin
        wr(REG_RDREQ, {19'b0, a});
        wait_idle();
        rd_chk($sformatf("rand_rd_%0h", a), REG_RDATA, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
      end
    end
    wait_idle();
    check("rand_wr_count", wlog.size() - base, exp_log.size());
    foreach (exp_log[i]) check($sformatf("rand_wr%0d", i), wlog[base+i], exp_log[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
